// File: rtl/systolic_bin_ctrl.sv
// Sequencer and binarizing drain for an N x N output-stationary PE array.
// Optional ADAPTIVE_THRESH_EN: threshold becomes the snapshot mean (N*N must be a power of two).
module systolic_bin_ctrl #(
  parameter int N   = 4,
  parameter int K_W = 8,
  parameter int Y_W = 32
) (
  input  logic           i_clk,
  input  logic           i_arst,
  input  logic           i_start,
  input  logic [K_W-1:0] i_k,
  input  logic [Y_W-1:0] i_threshold,
  output logic           o_busy,
  output logic           o_done,
  output logic           o_err,
  output logic           o_doProcess,
  output logic [K_W+4:0] o_step,
  output logic [N-1:0]   o_aLaneEn,
  output logic [N-1:0]   o_bLaneEn,
  output logic           o_capture,
  output logic [7:0]     o_rdIdx,
  input  logic [Y_W-1:0] i_ySel,
  output logic           o_pix,
  output logic           o_pixValid,
  input  logic           i_pixReady
);

  localparam int S_W = K_W + 5;
  localparam int T_W = Y_W + 8;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_COMPUTE = 3'd1;
  localparam logic [2:0] ST_CAPTURE = 3'd2;
  localparam logic [2:0] ST_DRAIN   = 3'd4;
`ifdef ADAPTIVE_THRESH_EN
  localparam logic [2:0] ST_MEAN    = 3'd3;
  localparam int         NN_LOG     = $clog2(N * N);
`endif

  localparam logic [7:0]     LAST_IDX = 8'(N * N - 1);
  localparam logic [S_W-1:0] SKEW     = S_W'(2 * N - 3);

`ifdef ADAPTIVE_THRESH_EN
  if (((N * N) & (N * N - 1)) != 0) begin : g_nn_pow2_chk
    $error("ADAPTIVE_THRESH_EN requires N*N to be a power of two");
  end
`endif

  logic [2:0]     state;
  logic [2:0]     state_nx;
  logic [S_W-1:0] step;
  logic [S_W-1:0] k_ext;
  logic [7:0]     rd_idx;
  logic [K_W-1:0] k_q;
  logic [T_W-1:0] thr_q;
  logic           done_q;
  logic           err_q;
  logic [N-1:0]   lane_en;

  logic start_ok;
  logic start_bad;
  logic in_comp;
  logic in_drain;
  logic last_step;
  logic xfer;
  logic last_xfer;

`ifdef ADAPTIVE_THRESH_EN
  logic [T_W-1:0] sum_q;
  logic [T_W-1:0] sum_nx;
  logic           in_mean;
  assign in_mean = (state == ST_MEAN);
  assign sum_nx  = sum_q + {8'b0, i_ySel};
`endif

  assign start_ok  = (state == ST_IDLE) && i_start && (i_k != '0);
  assign start_bad = (state == ST_IDLE) && i_start && (i_k == '0);
  assign in_comp   = (state == ST_COMPUTE);
  assign in_drain  = (state == ST_DRAIN);
  assign k_ext     = {5'b0, k_q};
  assign last_step = in_comp && (step == k_ext + SKEW);
  assign xfer      = in_drain && i_pixReady;
  assign last_xfer = xfer && (rd_idx == LAST_IDX);

  // Lane r carries real data for steps r .. r+K-1 (diagonal skew).
  always_comb begin
    lane_en = '0;
    for (int r = 0; r < N; r++) begin
      lane_en[r] = (step >= S_W'(r)) && (step < S_W'(r) + k_ext);
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:    if (start_ok) state_nx = ST_COMPUTE;
      ST_COMPUTE: if (last_step) state_nx = ST_CAPTURE;
`ifdef ADAPTIVE_THRESH_EN
      ST_CAPTURE: state_nx = ST_MEAN;
      ST_MEAN:    if (rd_idx == LAST_IDX) state_nx = ST_DRAIN;
`else
      ST_CAPTURE: state_nx = ST_DRAIN;
`endif
      ST_DRAIN:   if (last_xfer) state_nx = ST_IDLE;
      default:    state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      state  <= ST_IDLE;
      step   <= '0;
      rd_idx <= '0;
      k_q    <= '0;
      thr_q  <= '0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      state  <= state_nx;
      done_q <= last_xfer;
      err_q  <= start_bad;
      if (start_ok) begin
        k_q   <= i_k;
        thr_q <= {8'b0, i_threshold};
      end
      if (start_ok) begin
        step <= '0;
      end else if (in_comp) begin
        step <= step + 1'b1;
      end
      if (state == ST_CAPTURE || last_xfer) begin
        rd_idx <= '0;
      end else if (xfer) begin
        rd_idx <= rd_idx + 8'd1;
`ifdef ADAPTIVE_THRESH_EN
      end else if (in_mean) begin
        rd_idx <= (rd_idx == LAST_IDX) ? 8'd0 : rd_idx + 8'd1;
        if (rd_idx == LAST_IDX) thr_q <= sum_nx >> NN_LOG;
`endif
      end
    end
  end

`ifdef ADAPTIVE_THRESH_EN
  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      sum_q <= '0;
    end else if (state == ST_CAPTURE) begin
      sum_q <= '0;
    end else if (in_mean) begin
      sum_q <= sum_nx;
    end
  end
`endif

  assign o_busy      = (state != ST_IDLE);
  assign o_done      = done_q;
  assign o_err       = err_q;
  assign o_doProcess = in_comp || (state == ST_CAPTURE);
  assign o_step      = in_comp ? step : '0;
  assign o_aLaneEn   = in_comp ? lane_en : '0;
  assign o_bLaneEn   = in_comp ? lane_en : '0;
  assign o_capture   = (state == ST_CAPTURE);
  assign o_rdIdx     = rd_idx;
  assign o_pixValid  = in_drain;
  assign o_pix       = in_drain && ({8'b0, i_ySel} >= thr_q);

endmodule

// File: tb/tb_systolic_bin_ctrl.sv
// Randomized bench for systolic_bin_ctrl with a cycle-level behavioural model.
// Build with ADAPTIVE_THRESH_EN to check the mean-threshold variant.
`timescale 1ns/1ps
module tb_systolic_bin_ctrl;
  localparam int N   = 4;
  localparam int K_W = 8;
  localparam int Y_W = 32;
  localparam int NN  = N * N;

  logic           clk = 1'b0;
  logic           arst = 1'b1;
  logic           start = 1'b0;
  logic [K_W-1:0] k = '0;
  logic [Y_W-1:0] thr_in = '0;
  logic           busy, done, err, dp, cap, pix, pv;
  logic [K_W+4:0] step;
  logic [N-1:0]   alane, blane;
  logic [7:0]     rdidx;
  logic [Y_W-1:0] ysel;
  logic           rdy = 1'b0;

  logic [Y_W-1:0] snap [NN];

  int total = 0;
  int bad   = 0;

  systolic_bin_ctrl #(.N(N), .K_W(K_W), .Y_W(Y_W)) dut (
    .i_clk(clk), .i_arst(arst), .i_start(start), .i_k(k),
    .i_threshold(thr_in), .o_busy(busy), .o_done(done), .o_err(err),
    .o_doProcess(dp), .o_step(step), .o_aLaneEn(alane),
    .o_bLaneEn(blane), .o_capture(cap), .o_rdIdx(rdidx),
    .i_ySel(ysel), .o_pix(pix), .o_pixValid(pv), .i_pixReady(rdy)
  );

  always #5 clk = ~clk;

  always_comb begin
    ysel = '0;
    if (int'(rdidx) < NN) ysel = snap[int'(rdidx)];
  end

  task automatic chk(string nm, longint unsigned a, longint unsigned e);
    total++;
    if (a != e) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, a, e, $time);
    end
  endtask

  // model state
  bit             m_busy = 0;
  int             m_cyc, m_k, m_acc;
  logic [Y_W+7:0] m_thr;
  bit             m_done_p = 0, m_err_p = 0;
  int             n_proc, cap_at, n_xfer;
  logic [NN-1:0]  pix_bits;
  logic [N-1:0]   lane_hist [16];

  always @(negedge clk) begin
    int L, d0;
    longint unsigned sum;
    bit e_busy, e_dp, e_cap, e_pv, e_pix, e_done, e_err;
    int e_step, e_idx;
    logic [N-1:0] e_a;
    e_busy = 0; e_dp = 0; e_cap = 0; e_pv = 0; e_pix = 0;
    e_step = 0; e_idx = 0; e_a = '0;
    e_done = m_done_p; e_err = m_err_p;
    if (arst) begin
      m_busy = 0; m_done_p = 0; m_err_p = 0;
      e_done = 0; e_err = 0;
    end else if (m_busy) begin
      L  = m_k + 2 * N - 2;
      d0 = L + 1;
`ifdef ADAPTIVE_THRESH_EN
      d0 = L + 1 + NN;
`endif
      e_busy = 1;
      if (m_cyc < L) begin
        e_dp = 1; e_step = m_cyc;
        for (int r = 0; r < N; r++)
          e_a[r] = (r <= m_cyc) && (m_cyc < r + m_k);
      end else if (m_cyc == L) begin
        e_dp = 1; e_cap = 1;
      end else if (m_cyc < d0) begin
        e_idx = m_cyc - L - 1;
      end else begin
        e_pv = 1; e_idx = m_acc;
        e_pix = ({8'b0, snap[m_acc]} >= m_thr);
      end
    end
    chk("busy", busy, e_busy);
    chk("done", done, e_done);
    chk("err", err, e_err);
    chk("doProcess", dp, e_dp);
    chk("step", step, e_step);
    chk("aLaneEn", alane, e_a);
    chk("bLaneEn", blane, e_a);
    chk("capture", cap, e_cap);
    chk("pixValid", pv, e_pv);
    chk("pix", pix, e_pix);
    if (e_busy && !e_dp) chk("rdIdx", rdidx, e_idx);
    if (!arst) begin
      if (e_dp && !e_cap) n_proc++;
      if (e_cap) cap_at = n_proc;
      if (e_dp && !e_cap && m_cyc < 16) lane_hist[m_cyc] = alane;
      if (e_pv && rdy) begin pix_bits[m_acc] = pix; n_xfer++; end
      m_done_p = 0; m_err_p = 0;
      if (!m_busy) begin
        if (start && k == 0) m_err_p = 1;
        else if (start) begin
          m_busy = 1; m_cyc = 0; m_k = int'(k); m_acc = 0;
          n_proc = 0; cap_at = -1; n_xfer = 0; pix_bits = '0;
          m_thr = {8'b0, thr_in};
`ifdef ADAPTIVE_THRESH_EN
          sum = 0;
          for (int i = 0; i < NN; i++) sum += snap[i];
          m_thr = (Y_W+8)'(sum >> $clog2(NN));
`endif
        end
      end else begin
        if (e_pv && rdy) begin
          if (m_acc == NN - 1) begin m_busy = 0; m_done_p = 1; end
          else m_acc++;
        end
        m_cyc++;
      end
    end
  end

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic run_job(int kk, int thr, int mode, bit poke);
    int n;
    bit poked;
    poked = 0;
    start = 1; k = K_W'(kk); thr_in = Y_W'(thr); rdy = 1;
    cyc();
    start = 0; k = K_W'($urandom); thr_in = $urandom;
    n = 0;
    while (busy && n < 5000) begin
      case (mode)
        0: rdy = 1;
        1: rdy = ~rdy;
        default: rdy = ($urandom_range(0, 2) != 0);
      endcase
      start = 0;
      if (poke && pv && !poked) begin
        start = 1; k = 7; poked = 1;
      end
      cyc(); n++;
    end
    if (n >= 5000) begin
      total++; bad++;
      $display("FAIL job_timeout: got busy after %0d cycles expected idle", n);
    end
    start = 0; rdy = 0;
    cyc(); cyc();
  endtask

  initial begin
    int n;
    for (int i = 0; i < NN; i++) snap[i] = Y_W'(i * 10);
    repeat (3) cyc();
    arst = 0;
    cyc();

    // job 1: K=4, threshold 100, ramp snapshot
    run_job(4, 100, 0, 0);
    chk("job1_compute_cycles", n_proc, 10);
    chk("job1_capture_cycle", cap_at, 10);
    chk("job1_xfers", n_xfer, 16);
`ifdef ADAPTIVE_THRESH_EN
    chk("job1_pixels", pix_bits, 16'hFF00);
`else
    chk("job1_pixels", pix_bits, 16'hFC00);
`endif

    // lane skew with K=3, toggling ready, start poked during drain
    run_job(3, 55, 1, 1);
    chk("skew_t1", lane_hist[1], 4'b0011);
    chk("skew_t2", lane_hist[2], 4'b0111);
    chk("skew_t4", lane_hist[4], 4'b1100);
    chk("skew_t5", lane_hist[5], 4'b1000);
    chk("skew_t8", lane_hist[8], 4'b0000);
    chk("skew_xfers", n_xfer, 16);

    // K == 0 is rejected
    start = 1; k = 0; cyc();
    start = 0; cyc(); cyc();

    // asynchronous abort at t=3
    start = 1; k = 5; thr_in = 20; cyc();
    start = 0; n = 0;
    while (!(dp && step == 3) && n < 50) begin cyc(); n++; end
    chk("abort_reached_t3", step, 3);
    #2 arst = 1;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_doProcess", dp, 0);
    chk("abort_lanes", alane, 0);
    chk("abort_step", step, 0);
    @(posedge clk); #1 arst = 0;
    cyc();
    run_job(2, 70, 2, 0);
    chk("post_abort_xfers", n_xfer, 16);

    // randomized jobs
    for (int j = 0; j < 8; j++) begin
      for (int i = 0; i < NN; i++) snap[i] = $urandom_range(0, 160);
      run_job($urandom_range(1, 9), $urandom_range(0, 160),
              $urandom_range(0, 2), j[0]);
    end

    // maximum K
    for (int i = 0; i < NN; i++) snap[i] = $urandom_range(0, 255);
    run_job(255, 128, 2, 0);
    chk("kmax_compute_cycles", n_proc, 255 + 2 * N - 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/systolic_bin_ctrl.md
Name: systolic_bin_ctrl

Overview:
- Sequencer for the N x N output-stationary PE array used for image binarization.
- Per job: drives the array's process enable, generates skewed lane enables for the A (row) and B (column) edge feeders, and times the snapshot of the accumulated results.
- Drains the N*N results in raster order, thresholds each to one binary pixel, and streams pixels out with a valid/ready handshake.
- Sits between the frame/kernel buffers and the pixel output path.

Parameters:
- N, 4, array dimension (rows = columns); 2..16
- K_W, 8, width of the accumulation-length input
- Y_W, 32, width of a PE result

Ports:
- i_clk  in  1  clock
- i_arst  in  1  asynchronous active-high reset
- i_start  in  1  job start pulse; sampled only in IDLE
- i_k  in  K_W  accumulation length K; latched on accepted start
- i_threshold  in  Y_W  binarization threshold; latched on accepted start
- o_busy  out  1  high from accepted start until DONE exits
- o_done  out  1  one-cycle pulse when the last pixel is accepted
- o_err  out  1  one-cycle pulse when start is rejected (K == 0)
- o_doProcess  out  1  array process enable (all PEs)
- o_step  out  K_W+5  compute step counter t; feeders index lane r with t-r
- o_aLaneEn  out  N  bit r high when row feeder r presents real data; feeder drives 0 when low
- o_bLaneEn  out  N  bit c high when column feeder c presents real data; feeder drives 0 when low
- o_capture  out  1  one-cycle strobe; external snapshot registers load all PE outputs
- o_rdIdx  out  8  raster index (row*N+col) of the snapshot word to present on i_ySel
- i_ySel  in  Y_W  snapshot word selected by o_rdIdx (combinational mux, same cycle)
- o_pix  out  1  binary pixel, 1 when i_ySel >= threshold (unsigned compare)
- o_pixValid  out  1  pixel valid
- i_pixReady  in  1  downstream ready

Behaviour:
- Reset values: all outputs 0; state = IDLE; internal counters and latched K/threshold = 0. Reset mid-job aborts immediately; no o_done pulse.
- IDLE:
  - i_start with i_k != 0: latch K and threshold, t = 0, go to COMPUTE.
  - i_start with i_k == 0: pulse o_err, stay in IDLE.
- COMPUTE:
  - o_doProcess = 1; o_step = t.
  - o_aLaneEn[r] = (r <= t < r+K); o_bLaneEn[c] = (c <= t < c+K).
  - t increments each cycle. After step t = K+2N-3, go to CAPTURE; COMPUTE lasts exactly K+2N-2 cycles.
- CAPTURE (1 cycle):
  - o_doProcess = 1, all lane enables 0, o_capture = 1.
  - PE accumulators hold final sums this cycle and clear at the next edge once o_doProcess drops.
  - Next state: DRAIN with o_rdIdx = 0.
- DRAIN:
  - o_doProcess = 0; o_pixValid = 1; o_pix = (i_ySel >= threshold).
  - On o_pixValid & i_pixReady: o_rdIdx++. On acceptance of index N*N-1: pulse o_done, go to IDLE.
  - While i_pixReady is low, o_pix/o_rdIdx stay stable (AXI-style: valid never drops without a transfer).
- o_busy = (state != IDLE).
- i_start outside IDLE is ignored; there is no queueing.
- K = 2^K_W - 1 is supported; o_step never wraps (width K_W+5 covers K+2N).
- Latency from start to first o_pixValid: K+2N cycles.
- The implementation includes the full state decode; no illegal state is reachable, and a default branch returns to IDLE.

Optional Feature:
- Macro: ADAPTIVE_THRESH_EN.
- Defined:
  - The DRAIN state is preceded by a MEAN pass: o_rdIdx sweeps 0..N*N-1 one per cycle with o_pixValid = 0.
  - The i_ySel words are summed into a Y_W+8-bit accumulator.
  - The threshold used in DRAIN becomes sum >> log2(N*N), replacing i_threshold.
  - N*N must be a power of two; the compile fails otherwise.
  - First-pixel latency becomes K+2N+N*N.
- Undefined: the latched i_threshold is used and the MEAN pass is absent.

Test Plan:
- N=4, K=4, threshold=100, snapshot values 0..15 x 10 -> COMPUTE exactly 10 cycles; o_capture at cycle 10; pixels 0 for idx 0..9 and 1 for idx 10..15; o_done one cycle after idx 15 is accepted.
- Lane skew, N=4, K=3 -> o_aLaneEn[2] high only at t=2..4; o_aLaneEn[0] only at t=0..2; at t=8 all lanes 0.
- i_pixReady toggled 1/0 each cycle -> 16 transfers in 32 cycles; o_pix/o_rdIdx stable during stalls; no skipped or duplicate indices.
- i_start with i_k=0 -> o_err pulse; o_busy stays 0. i_start during DRAIN -> ignored; job completes unchanged.
- i_arst asserted in COMPUTE at t=3 -> all outputs 0 asynchronously; after release, a fresh start with K=2 completes normally with no o_done from the aborted job.
- ADAPTIVE_THRESH_EN, N=2, snapshot {10,20,30,40} -> threshold 25; pixels 0,0,1,1.
